// File: rtl/regfile_dump_sequencer.sv
// regfile_dump_sequencer
//   Streams the contents of registers 0..NUM_REGS-1 out of a register-file read port as
//   a sequence of bytes over a valid/ready transmitter interface. Each register is read
//   once into a holding word (LOAD) and then sent as four bytes (SEND). The byte order is
//   selected by MSB_FIRST. A one-cycle Done pulse marks the end of a complete dump.
//
// Parameters
//   NUM_REGS   number of registers dumped, starting at index 0 (1..32)
//   MSB_FIRST  1: byte [31:24] first, 0: byte [7:0] first
//
// Ports
//   Clock         in   system clock, rising edge
//   ResetN        in   asynchronous active-low reset
//   Start         in   begin a dump (only sampled while idle)
//   Abort         in   synchronous cancel of a dump in progress
//   ReadRegister  out  register-file read address (read port 1)
//   ReadData      in   combinational read data for ReadRegister
//   TxData        out  byte offered to the transmitter
//   TxValid       out  TxData valid
//   TxReady       in   transmitter accepts the offered byte
//   Busy          out  dump in progress
//   Done          out  one-cycle pulse when a dump completes
module regfile_dump_sequencer #(
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic        Abort,
  output logic [4:0]  ReadRegister,
  input  logic [31:0] ReadData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  output logic        Busy,
  output logic        Done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [4:0] LastReg = 5'(NUM_REGS - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  reg_idx_q, reg_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_sel;
  logic [7:0]  byte_mux;

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    case (state_q)
      StIdle: begin
        if (Start && !Abort) begin
          state_d   = StLoad;
          reg_idx_d = '0;
        end
      end
      StLoad: begin
        if (Abort) begin
          state_d = StIdle;
        end else begin
          word_d     = ReadData;
          byte_idx_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        // Abort wins over a simultaneous handshake: the offered byte is dropped.
        if (Abort) begin
          state_d = StIdle;
        end else if (TxReady) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else if (reg_idx_q != LastReg) begin
            reg_idx_d = reg_idx_q + 5'd1;
            state_d   = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Abort is deliberately ignored here so the Done pulse is never lost.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= StIdle;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  // Map transmit order onto the physical byte lane of the held word.
  always_comb begin
    byte_sel = MSB_FIRST ? (2'd3 - byte_idx_q) : byte_idx_q;
    case (byte_sel)
      2'd0:    byte_mux = word_q[7:0];
      2'd1:    byte_mux = word_q[15:8];
      2'd2:    byte_mux = word_q[23:16];
      default: byte_mux = word_q[31:24];
    endcase
  end

  always_comb begin
    ReadRegister = reg_idx_q;
    TxValid      = (state_q == StSend);
    TxData       = TxValid ? byte_mux : 8'h00;
    Busy         = (state_q != StIdle);
    Done         = (state_q == StDone);
  end

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
module tb_regfile_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, tx_ready;
  logic [4:0]  read_register;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  // Second instance: LSB-first, two registers.
  logic        start2, abort2, tx_ready2;
  logic [4:0]  read_register2;
  logic [31:0] read_data2;
  logic [7:0]  tx_data2;
  logic        tx_valid2, busy2, done2;

  logic [31:0] rf  [32];
  logic [31:0] rf2 [32];

  int n_vec, n_err, cyc, done_cnt, done_cyc, done2_cnt;
  logic [7:0] cap_q[$];
  logic [7:0] cap2_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always_comb read_data  = rf[read_register];
  always_comb read_data2 = rf2[read_register2];

  regfile_dump_sequencer u_dut (
    .Clock        (clk),
    .ResetN       (rst_n),
    .Start        (start),
    .Abort        (abort),
    .ReadRegister (read_register),
    .ReadData     (read_data),
    .TxData       (tx_data),
    .TxValid      (tx_valid),
    .TxReady      (tx_ready),
    .Busy         (busy),
    .Done         (done)
  );

  regfile_dump_sequencer #(
    .NUM_REGS  (2),
    .MSB_FIRST (1'b0)
  ) u_lsb (
    .Clock        (clk),
    .ResetN       (rst_n),
    .Start        (start2),
    .Abort        (abort2),
    .ReadRegister (read_register2),
    .ReadData     (read_data2),
    .TxData       (tx_data2),
    .TxValid      (tx_valid2),
    .TxReady      (tx_ready2),
    .Busy         (busy2),
    .Done         (done2)
  );

  // Record what will happen at the coming edge, then advance to 1 time unit past it.
  task automatic tick();
    if (rst_n) begin
      if (tx_valid && tx_ready && !abort) cap_q.push_back(tx_data);
      if (tx_valid2 && tx_ready2) cap2_q.push_back(tx_data2);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done2) done2_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_run();
    cap_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Expected byte stream: registers in index order, four bytes each in the chosen order.
  task automatic build_exp(input int n, input bit msb, input bit use_rf2);
    logic [31:0] w;
    int sh;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      w = use_rf2 ? rf2[r] : rf[r];
      for (int b = 0; b < 4; b++) begin
        sh = msb ? (24 - 8 * b) : (8 * b);
        exp_q.push_back(8'((w >> sh) & 32'hFF));
      end
    end
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
  endtask

  task automatic drain(input int budget, input int ready_pct);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      tick();
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (read_register !== 5'd0) begin n_err++;
      $display("FAIL reset_readreg got %0d want 0", read_register); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++;
      $display("FAIL reset_txdata got %02h want 00", tx_data); end
    n_vec++; if ({tx_valid, busy, done} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags got %b want 000", {tx_valid, busy, done}); end
    n_vec++; if ({tx_valid2, busy2, done2} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags_lsb got %b want 000", {tx_valid2, busy2, done2}); end
    rst_n = 1'b1;
    // First Start right after release must be honoured.
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL first_start_busy got %b want 1", busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL abort_in_load_busy got %b want 0", busy); end
    // Start and Abort together while idle: stay idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL start_abort_idle_busy got %b want 0", busy); end
    tick();
  endtask

  task automatic test_full_dump();
    int s;
    logic [7:0] r29 [4];
    r29 = '{8'h00, 8'h00, 8'hD4, 8'h80};
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rf[29] = 32'd54400;
    build_exp(32, 1'b1, 1'b0);
    clear_run();
    tx_ready = 1'b1;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    n_vec++; if ({busy, tx_valid, read_register} !== {1'b1, 1'b0, 5'd0}) begin n_err++;
      $display("FAIL full_load_cycle got busy=%b valid=%b reg=%0d want 1 0 0",
               busy, tx_valid, read_register); end
    drain(400, 100);
    n_vec++; if (done_cnt !== 1) begin n_err++;
      $display("FAIL full_done_count got %0d want 1", done_cnt); end
    n_vec++; if (done_cyc !== s + 161) begin n_err++;
      $display("FAIL full_done_time got %0d want %0d", done_cyc - s, 161); end
    n_vec++; if (cap_q.size() !== 128) begin n_err++;
      $display("FAIL full_byte_count got %0d want 128", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL full_byte[%0d] got %02h want %02h", i, cap_q[i], exp_q[i]); end
    end
    if (cap_q.size() == 128) begin
      for (int b = 0; b < 4; b++) begin
        n_vec++; if (cap_q[116 + b] !== r29[b]) begin n_err++;
          $display("FAIL reg29_byte%0d got %02h want %02h", b, cap_q[116 + b], r29[b]); end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL full_busy_after got %b want 0", busy); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] want [8];
    want = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        rf2[0] = 32'h0;
        rf2[1] = 32'h01020304;
      end else begin
        rf2[0] = $urandom();
        rf2[1] = $urandom();
      end
      build_exp(2, 1'b0, 1'b1);
      cap2_q.delete();
      done2_cnt = 0;
      tx_ready2 = 1'b1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 100 && done2_cnt == 0; i++) begin
        tx_ready2 = (pass == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        tick();
      end
      n_vec++; if (done2_cnt !== 1) begin n_err++;
        $display("FAIL lsb_done_count got %0d want 1", done2_cnt); end
      n_vec++; if (cap2_q.size() !== 8) begin n_err++;
        $display("FAIL lsb_byte_count got %0d want 8", cap2_q.size()); end
      for (int i = 0; i < cap2_q.size() && i < 8; i++) begin
        n_vec++; if (cap2_q[i] !== exp_q[i]) begin n_err++;
          $display("FAIL lsb_byte[%0d] got %02h want %02h", i, cap2_q[i], exp_q[i]); end
        if (pass == 0) begin
          n_vec++; if (cap2_q[i] !== want[i]) begin n_err++;
            $display("FAIL lsb_fixed[%0d] got %02h want %02h", i, cap2_q[i], want[i]); end
        end
      end
    end
    tx_ready2 = 1'b0;
  endtask

  task automatic test_backpressure();
    int s;
    bit held;
    randomize_rf();
    build_exp(32, 1'b1, 1'b0);
    clear_run();
    held = 1'b0;
    tx_ready = 1'b1;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      if (!held && cap_q.size() == 22 && tx_valid) begin
        held = 1'b1;
        tx_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
          n_vec++; if (tx_valid !== 1'b1 || tx_data !== exp_q[22]) begin n_err++;
            $display("FAIL hold_cycle%0d got valid=%b data=%02h want 1 %02h",
                     k, tx_valid, tx_data, exp_q[22]); end
          tick();
        end
        tx_ready = 1'b1;
      end else begin
        tick();
      end
    end
    n_vec++; if (held !== 1'b1) begin n_err++;
      $display("FAIL hold_reached got %b want 1", held); end
    n_vec++; if (done_cnt !== 1 || done_cyc !== s + 168) begin n_err++;
      $display("FAIL hold_done got count=%0d at=%0d want 1 at 168", done_cnt, done_cyc - s); end
    n_vec++; if (cap_q.size() !== 128) begin n_err++;
      $display("FAIL hold_byte_count got %0d want 128", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL hold_byte[%0d] got %02h want %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back_start();
    randomize_rf();
    build_exp(32, 1'b1, 1'b0);
    clear_run();
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < 800 && done_cnt == 0; i++) begin
      tx_ready = ($urandom_range(0, 99) < 70);
      start = (cap_q.size() == 28) || ($urandom_range(0, 19) == 0);
      tick();
    end
    start = 1'b0;
    tx_ready = 1'b1;
    repeat (20) tick();
    n_vec++; if (done_cnt !== 1) begin n_err++;
      $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
    n_vec++; if (cap_q.size() !== 128) begin n_err++;
      $display("FAIL b2b_byte_count got %0d want 128", cap_q.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL b2b_busy_after got %b want 0", busy); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL b2b_byte[%0d] got %02h want %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    randomize_rf();
    build_exp(32, 1'b1, 1'b0);
    clear_run();
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && cap_q.size() != 41; i++) tick();
    n_vec++; if (cap_q.size() !== 41 || tx_valid !== 1'b1) begin n_err++;
      $display("FAIL abort_reach got bytes=%0d valid=%b want 41 1", cap_q.size(), tx_valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++; if ({tx_valid, busy, done} !== 3'b000) begin n_err++;
      $display("FAIL abort_next got %b want 000", {tx_valid, busy, done}); end
    repeat (20) tick();
    n_vec++; if (done_cnt !== 0 || cap_q.size() !== 41) begin n_err++;
      $display("FAIL abort_quiet got done=%0d bytes=%0d want 0 41", done_cnt, cap_q.size()); end
    clear_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (read_register !== 5'd0 || busy !== 1'b1) begin n_err++;
      $display("FAIL abort_restart got reg=%0d busy=%b want 0 1", read_register, busy); end
    drain(600, 80);
    n_vec++; if (done_cnt !== 1 || cap_q.size() !== 128) begin n_err++;
      $display("FAIL abort_rerun got done=%0d bytes=%0d want 1 128", done_cnt, cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (cap_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL abort_byte[%0d] got %02h want %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_dump();
    randomize_rf();
    clear_run();
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && cap_q.size() != 13; i++) tick();
    n_vec++; if (cap_q.size() !== 13 || busy !== 1'b1) begin n_err++;
      $display("FAIL rstmid_reach got bytes=%0d busy=%b want 13 1", cap_q.size(), busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (read_register !== 5'd0 || tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL rstmid_async got reg=%0d valid=%b busy=%b want 0 0 0",
               read_register, tx_valid, busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) tick();
    n_vec++; if (done_cnt !== 0 || busy !== 1'b0) begin n_err++;
      $display("FAIL rstmid_after got done=%0d busy=%b want 0 0", done_cnt, busy); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; done_cnt = 0; done_cyc = -1; done2_cnt = 0;
    start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; tx_ready2 = 1'b0;
    for (int i = 0; i < 32; i++) begin rf[i] = '0; rf2[i] = '0; end
    rst_n = 1'b1;
    #1;
    test_reset();
    test_full_dump();
    test_lsb_first();
    test_backpressure();
    test_back_to_back_start();
    test_abort();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
